// File: rtl/kan_sched_pkg.sv
// kan_array_scheduler shared types: FSM states, weight-buffer modes, helpers.
// Imported by the arbiter and the scheduler top.
package kan_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_REQ,
        S_LOAD_WAIT,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [7:0] CFG_MODE_LOAD = 8'h01;
    localparam logic [7:0] CFG_MODE_IDLE = 8'h00;

    // LSB position of requester idx's slice in the flattened req_len bus
    function automatic int req_len_lo(input int idx, input int len_w);
        return idx * len_w;
    endfunction

endpackage

// File: rtl/kan_array_scheduler_rr_arbiter.sv
// kan_rr_arbiter: combinational round-robin pick; first set req at or
// after ptr wins. Pointer register lives in the parent.
module kan_rr_arbiter
    import kan_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   win_idx
);

    logic found;

    // Search [ptr, NUM_REQ) first, then wrap to [0, NUM_REQ)
    always_comb begin
        winner  = '0;
        win_idx = '0;
        found   = 1'b0;
        if (enable) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] && (j >= int'(ptr))) begin
                    found     = 1'b1;
                    winner[j] = 1'b1;
                    win_idx   = IDX_W'(j);
                end
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j]) begin
                    found     = 1'b1;
                    winner[j] = 1'b1;
                    win_idx   = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/kan_array_scheduler.sv
// kan_array_scheduler: shares one systolic array + weight buffer among
// NUM_REQ requesters. Optional watchdog: KAN_SCHED_WATCHDOG_EN.
module kan_array_scheduler
    import kan_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int LEN_W          = 16,
    parameter int DRAIN_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*LEN_W-1:0]   req_len,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       err,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] job_id,
    output logic [7:0]                 wb_config_mode,
    input  logic                       wb_buffer_ready,
    input  logic                       wb_weights_valid,
    input  logic                       src_valid,
    output logic                       src_ready,
    output logic                       arr_in_valid,
    input  logic                       arr_in_ready,
    input  logic                       arr_active
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int IDL_W = $clog2(DRAIN_CYCLES + 1);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   job_id_q, job_id_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [IDL_W-1:0]   idle_q, idle_d;
    logic [7:0]         mode_q, mode_d;
    logic [NUM_REQ-1:0] win;
    logic [IDX_W-1:0]   win_idx;
    logic [LEN_W-1:0]   len_sel;

`ifdef KAN_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
`endif

    kan_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .enable  (state_q == S_IDLE),
        .winner  (win),
        .win_idx (win_idx)
    );

    // Pick the winner's vector count out of the flattened bus
    always_comb begin
        len_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                len_sel = req_len[req_len_lo(i, LEN_W) +: LEN_W];
            end
        end
    end

    // Next-state and job bookkeeping
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        job_id_d = job_id_q;
        ptr_d    = ptr_q;
        len_d    = len_q;
        beat_d   = beat_q;
        idle_d   = '0;
        mode_d   = mode_q;
`ifdef KAN_SCHED_WATCHDOG_EN
        wd_d     = '0;
        err_d    = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (|win) begin
                    grant_d  = win;
                    job_id_d = win_idx;
                    len_d    = len_sel;
                    beat_d   = '0;
                    state_d  = S_LOAD_REQ;
                end
            end
            S_LOAD_REQ: begin
                if (wb_buffer_ready) begin
                    mode_d  = CFG_MODE_LOAD;
                    state_d = S_LOAD_WAIT;
                end
            end
            S_LOAD_WAIT: begin
                if (wb_weights_valid) begin
                    mode_d  = CFG_MODE_IDLE;
                    state_d = (len_q == '0) ? S_DRAIN : S_STREAM;
                end
            end
            S_STREAM: begin
                if (src_valid && arr_in_ready) begin
                    if (beat_q == len_q - LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (idle_q == IDL_W'(DRAIN_CYCLES)) begin
                    state_d = S_DONE;
                end else if (!arr_active) begin
                    idle_d = idle_q + 1'b1;
                end
            end
            S_DONE: begin
                grant_d = '0;
                ptr_d   = (job_id_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                           : job_id_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef KAN_SCHED_WATCHDOG_EN
        if (state_q inside {S_LOAD_REQ, S_LOAD_WAIT, S_DRAIN}) begin
            if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_DONE;
                mode_d  = CFG_MODE_IDLE;
                err_d   = 1'b1;
                idle_d  = '0;
            end else if (state_d == state_q) begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    // State and job registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            job_id_q <= '0;
            ptr_q    <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            idle_q   <= '0;
            mode_q   <= CFG_MODE_IDLE;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            job_id_q <= job_id_d;
            ptr_q    <= ptr_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            idle_q   <= idle_d;
            mode_q   <= mode_d;
        end
    end

`ifdef KAN_SCHED_WATCHDOG_EN
    // Watchdog counter and abort flag (flag is high only in DONE)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    // No watchdog in this build; err is constant low
    assign err = (TIMEOUT_CYCLES < 0);
`endif

    assign busy           = (state_q != S_IDLE);
    assign grant          = grant_q;
    assign job_id         = job_id_q;
    assign done           = (state_q == S_DONE) ? grant_q : '0;
    assign wb_config_mode = mode_q;
    assign arr_in_valid   = (state_q == S_STREAM) && src_valid;
    assign src_ready      = (state_q == S_STREAM) && arr_in_ready;

endmodule

// File: tb/tb_kan_array_scheduler.sv
// Self-checking bench for kan_array_scheduler: directed plan steps plus
// randomized jobs checked against a job-level round-robin/timing model.
module tb_kan_array_scheduler;

    localparam int N  = 4;
    localparam int LW = 16;
    localparam int D  = 4;
    localparam int TO = 1024;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            err;
    logic            busy;
    logic [1:0]      job_id;
    logic [7:0]      wb_config_mode;
    logic            wb_buffer_ready;
    logic            wb_weights_valid;
    logic            src_valid;
    logic            src_ready;
    logic            arr_in_valid;
    logic            arr_in_ready;
    logic            arr_active;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int ptr_m     = 0;
    int last_done = -100;

    kan_array_scheduler #(
        .NUM_REQ        (N),
        .LEN_W          (LW),
        .DRAIN_CYCLES   (D),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req              (req),
        .req_len          (req_len),
        .grant            (grant),
        .done             (done),
        .err              (err),
        .busy             (busy),
        .job_id           (job_id),
        .wb_config_mode   (wb_config_mode),
        .wb_buffer_ready  (wb_buffer_ready),
        .wb_weights_valid (wb_weights_valid),
        .src_valid        (src_valid),
        .src_ready        (src_ready),
        .arr_in_valid     (arr_in_valid),
        .arr_in_ready     (arr_in_ready),
        .arr_active       (arr_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_len(input int i, input int l);
        req_len[i*LW +: LW] = LW'(l);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_src_ready"}, src_ready, 0);
        chk({tag, "_in_valid"}, arr_in_valid, 0);
        chk({tag, "_mode"}, wb_config_mode, 0);
        chk({tag, "_job_id"}, job_id, 0);
    endtask

    // One whole job: wait for grant, act as weight buffer/array/source,
    // and compare against expected owner, beat count and done timing.
    // wv_dly < 0: weights_valid held high before LOAD_WAIT entry.
    task automatic run_job(input int bp, input int act, input int wv_dly,
                           input int rdy_dly, input bit drop, input bit b2b);
        int owner, len, g, mode_t, wv_t, lb, beats, done_t, r;
        bit in_stream;
        owner = rr_pick(req, ptr_m);
        len   = int'(req_len[owner*LW +: LW]);
        wb_weights_valid = 1'b0;
        wb_buffer_ready  = 1'b0;
        arr_active       = 1'b0;
        g = -1;
        for (int t = 0; t < 20; t++) begin
            step();
            #1;
            if (grant !== '0) begin
                g = cyc;
                break;
            end
        end
        chk("grant_seen", g >= 0, 1);
        if (g < 0) return;
        chk("grant", grant, 1 << owner);
        chk("job_id", job_id, owner);
        chk("busy", busy, 1);
        if (b2b) chk("job_gap", g - last_done, 2);
        if (drop) req = '0;
        mode_t = -1;
        wv_t   = -1;
        lb     = -1;
        beats  = 0;
        done_t = -1;
        r      = (rdy_dly < 1) ? 1 : rdy_dly;
        for (int t = 0; t < 400 && done_t < 0; t++) begin
            step();
            wb_buffer_ready = (cyc - g >= rdy_dly);
            if (wv_dly < 0) wb_weights_valid = (wv_t < 0);
            else wb_weights_valid = (mode_t >= 0 && wv_t < 0 &&
                                     cyc - mode_t >= wv_dly);
            case (bp)
                0: begin
                    src_valid    = 1'b1;
                    arr_in_ready = 1'b1;
                end
                1: begin
                    src_valid    = 1'b1;
                    arr_in_ready = cyc[0];
                end
                default: begin
                    src_valid    = 1'($urandom_range(0, 1));
                    arr_in_ready = 1'($urandom_range(0, 1));
                end
            endcase
            arr_active = (lb >= 0 && act > 0 && cyc - lb <= act);
            #1;
            in_stream = (wv_t >= 0 && cyc > wv_t && beats < len);
            chk("in_valid_gate", arr_in_valid, in_stream & src_valid);
            chk("src_ready_gate", src_ready, in_stream & arr_in_ready);
            if (arr_in_valid && arr_in_ready) begin
                beats++;
                if (beats == len) lb = cyc;
            end
            if (mode_t < 0 && wb_config_mode == 8'h01) begin
                mode_t = cyc;
                chk("load_start", cyc, g + r + 1);
            end
            if (wv_t >= 0 && cyc == wv_t + 1)
                chk("load_end", wb_config_mode, 0);
            if (wb_weights_valid && wv_t < 0 && wb_config_mode == 8'h01) begin
                wv_t = cyc;
                if (len == 0) lb = cyc;
            end
            if (done !== '0) begin
                done_t = cyc;
                chk("done_owner", done, 1 << owner);
                chk("done_err", err, 0);
                chk("beats", beats, len);
            end
        end
        chk("done_seen", done_t >= 0, 1);
        if (done_t >= 0) begin
            if (act == 0) chk("done_lat", done_t - lb, D + 2);
            else chk("drain_min", (done_t - lb) >= (act + D + 1), 1);
        end
        ptr_m     = (owner + 1) % N;
        last_done = done_t;
        arr_active = 1'b0;
        step();
        #1;
        chk("done_pulse", done, 0);
        chk("grant_clear", grant, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int seen, ok;
        logic [N-1:0] m;
        rst_n            = 1'b0;
        req              = '0;
        req_len          = '0;
        wb_buffer_ready  = 1'b1;
        wb_weights_valid = 1'b1;
        src_valid        = 1'b1;
        arr_in_ready     = 1'b1;
        arr_active       = 1'b0;
        #2;
        check_reset_outputs("reset");
        step();
        step();
        rst_n = 1'b1;

        // Fairness from reset pointer: 0,1,2,3,0
        for (int i = 0; i < N; i++) set_len(i, 1);
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            chk("rr_order", rr_pick(req, ptr_m), (j == 4) ? 0 : j);
            run_job(0, 0, 1, 0, j == 4, j > 0);
        end

        // Single job, len 3, weights valid 2 cycles after load request
        set_len(0, 3);
        req = 4'b0001;
        run_job(0, 0, 2, 0, 1'b1, 1'b0);

        // Backpressure: arr_in_ready toggles, len 4
        set_len(2, 4);
        req = 4'b0100;
        run_job(1, 0, 1, 2, 1'b1, 1'b0);

        // Zero length, weights already valid at LOAD_WAIT entry
        set_len(1, 0);
        req = 4'b0010;
        run_job(0, 0, -1, 0, 1'b1, 1'b0);

        // Drain extension: array busy 10 cycles past last beat
        set_len(3, 2);
        req = 4'b1000;
        run_job(0, 10, 0, 1, 1'b1, 1'b0);

        // Randomized jobs
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < N; i++) set_len(i, $urandom_range(0, 6));
            m = N'($urandom_range(1, 15));
            req = m;
            run_job(2, $urandom_range(0, 5), $urandom_range(0, 4) - 1,
                    $urandom_range(0, 3), 1'b1, 1'b0);
        end

        // Reset in the middle of STREAM
        for (int i = 0; i < N; i++) set_len(i, 8);
        req              = 4'b0110;
        wb_buffer_ready  = 1'b1;
        wb_weights_valid = 1'b1;
        src_valid        = 1'b1;
        arr_in_ready     = 1'b1;
        seen = 0;
        for (int t = 0; t < 30 && seen < 2; t++) begin
            step();
            #1;
            if (arr_in_valid) seen++;
            if (grant !== '0) req = '0;
        end
        chk("stream_reached", seen, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        step();
        rst_n = 1'b1;
        ptr_m = 0;
        set_len(1, 2);
        set_len(3, 2);
        req = 4'b1010;
        run_job(0, 0, 1, 0, 1'b1, 1'b0);

`ifdef KAN_SCHED_WATCHDOG_EN
        // Watchdog: weights never arrive
        set_len(0, 2);
        req              = 4'b0001;
        wb_buffer_ready  = 1'b1;
        wb_weights_valid = 1'b0;
        ok = -1;
        seen = -1;
        for (int t = 0; t < TO + 50 && ok < 0; t++) begin
            step();
            #1;
            if (grant !== '0) req = '0;
            if (seen < 0 && wb_config_mode == 8'h01) seen = cyc;
            if (done !== '0) begin
                ok = cyc;
                chk("wd_done", done, 1);
                chk("wd_err", err, 1);
                chk("wd_mode", wb_config_mode, 0);
            end
        end
        chk("wd_time", ok - seen, TO);
        step();
        #1;
        chk("wd_err_pulse", err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
